// File: rtl/change_dispenser_if.sv
// Handshake/status bundle between the vending controller and the change dispenser.
// The abort input exists only when CHANGE_ABORT_EN is defined.
interface change_dispenser_if;
  logic       start;
  logic [7:0] change_money;
`ifdef CHANGE_ABORT_EN
  logic       abort;
`endif
  logic       busy;
  logic       done;
  logic       out_fifty;
  logic       out_twenty;
  logic       out_ten;
  logic       out_five;
  logic       out_one;
  logic [7:0] remain_money;
  logic [3:0] coin_count;
  logic [1:0] state_out;

  modport master (
`ifdef CHANGE_ABORT_EN
    output abort,
`endif
    output start, change_money,
    input  busy, done, out_fifty, out_twenty, out_ten, out_five, out_one,
    input  remain_money, coin_count, state_out
  );

  modport slave (
`ifdef CHANGE_ABORT_EN
    input  abort,
`endif
    input  start, change_money,
    output busy, done, out_fifty, out_twenty, out_ten, out_five, out_one,
    output remain_money, coin_count, state_out
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change dispenser: one coin/note pulse per SELECT, PULSE_GAP idle cycles between pulses.
// Optional CHANGE_ABORT_EN adds an abort input that ends a transaction early.
module change_dispenser #(
  parameter int unsigned PULSE_GAP = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  change_dispenser_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_GAP    = 2'd2
  } state_e;

  localparam logic [3:0] GAP_LOAD = PULSE_GAP[3:0];

  state_e      state_q, state_d;
  logic [3:0]  gap_q, gap_d;
  logic [7:0]  remain_q, remain_d;
  logic [3:0]  coin_q, coin_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [4:0]  out_q, out_d;   // {fifty, twenty, ten, five, one}
  logic        abort_s;

`ifdef CHANGE_ABORT_EN
  assign abort_s = bus.abort;
`else
  assign abort_s = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    remain_d = remain_q;
    coin_d   = coin_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    out_d    = 5'b00000;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          remain_d = bus.change_money;
          coin_d   = 4'd0;
          busy_d   = 1'b1;
          state_d  = S_SELECT;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_SELECT: begin
        if (abort_s || (remain_q == 8'd0)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          gap_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          // Largest denomination not exceeding the remainder, so no underflow.
          if (remain_q >= 8'd50) begin
            out_d    = 5'b10000;
            remain_d = remain_q - 8'd50;
          end else if (remain_q >= 8'd20) begin
            out_d    = 5'b01000;
            remain_d = remain_q - 8'd20;
          end else if (remain_q >= 8'd10) begin
            out_d    = 5'b00100;
            remain_d = remain_q - 8'd10;
          end else if (remain_q >= 8'd5) begin
            out_d    = 5'b00010;
            remain_d = remain_q - 8'd5;
          end else begin
            out_d    = 5'b00001;
            remain_d = remain_q - 8'd1;
          end
          coin_d  = coin_q + 4'd1;
          gap_d   = GAP_LOAD;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (abort_s) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          gap_d   = 4'd0;
          state_d = S_IDLE;
        end else if (gap_q <= 4'd1) begin
          gap_d   = 4'd0;
          state_d = S_SELECT;
        end else begin
          gap_d   = gap_q - 4'd1;
          state_d = S_GAP;
        end
      end
      default: begin
        busy_d  = 1'b0;
        gap_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset is asynchronous and active high.
  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      state_q  <= S_IDLE;
      gap_q    <= 4'd0;
      remain_q <= 8'd0;
      coin_q   <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      out_q    <= 5'b00000;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      remain_q <= remain_d;
      coin_q   <= coin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      out_q    <= out_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.out_fifty    = out_q[4];
  assign bus.out_twenty   = out_q[3];
  assign bus.out_ten      = out_q[2];
  assign bus.out_five     = out_q[1];
  assign bus.out_one      = out_q[0];
  assign bus.remain_money = remain_q;
  assign bus.coin_count   = coin_q;
  assign bus.state_out    = state_q;

endmodule
